router_wr_ctrl: RTL and testbench



---
 rtl/router_wr_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_router_wr_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_wr_ctrl.sv
`timescale 1ns/1ps
// router_wr_ctrl: write-side packet controller for the 1x3 router (header decode, FIFO writes, parity check).
// Define ROUTER_WR_STATS_EN to add saturating pkt_cnt/err_cnt/drop_cnt outputs.
module router_wr_ctrl #(
   parameter int NUM_PORTS = 3,
   parameter int DW        = 8
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [DW-1:0]        data_in,
   input  logic [NUM_PORTS-1:0] fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   output logic                 busy,
   output logic                 error,
   output logic [NUM_PORTS-1:0] wr_en,
   output logic [DW-1:0]        fifo_din,
   output logic                 lfd_state
`ifdef ROUTER_WR_STATS_EN
   ,
   output logic [15:0]          pkt_cnt,
   output logic [15:0]          err_cnt,
   output logic [15:0]          drop_cnt
`endif
);

   localparam int CW = DW - 2;

   typedef enum logic [3:0] {
      ST_DECODE,
      ST_WAIT_EMPTY,
      ST_LFD,
      ST_LOAD_DATA,
      ST_FULL,
      ST_LAF,
      ST_LOAD_PARITY,
      ST_PFULL,
      ST_CHECK
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] header_q, header_d;
   logic [DW-1:0] hold_q, hold_d;
   logic [DW-1:0] parity_q, parity_d;
   logic [DW-1:0] rx_parity_q, rx_parity_d;
   logic [CW-1:0] count_q, count_d;
   logic          error_q, error_d;

   logic          write;
   logic [DW-1:0] wbyte;
   logic [3:0]    full_vec, empty_vec, sr_vec;
   logic [1:0]    addr_q, in_addr;
   logic [CW-1:0] len_q;
   logic          in_addr_ok, sel_full, sel_empty, sel_sr;

   // Pad the per-port vectors to the full 2-bit address space so any address indexes safely.
   always_comb begin
      full_vec  = '0;
      empty_vec = '0;
      sr_vec    = '0;
      full_vec[NUM_PORTS-1:0]  = fifo_full;
      empty_vec[NUM_PORTS-1:0] = fifo_empty;
      sr_vec[NUM_PORTS-1:0]    = soft_reset;
   end

   assign addr_q     = header_q[1:0];
   assign len_q      = header_q[DW-1:2];
   assign in_addr    = data_in[1:0];
   assign in_addr_ok = (int'(in_addr) < NUM_PORTS);
   assign sel_full   = full_vec[addr_q];
   assign sel_empty  = empty_vec[addr_q];
   assign sel_sr     = sr_vec[addr_q];

   always_comb begin
      state_d     = state_q;
      header_d    = header_q;
      hold_d      = hold_q;
      parity_d    = parity_q;
      rx_parity_d = rx_parity_q;
      count_d     = count_q;
      error_d     = error_q;
      write       = 1'b0;
      wbyte       = '0;
      if (state_q != ST_DECODE && sel_sr) begin
         state_d = ST_DECODE;
      end else begin
         case (state_q)
            ST_DECODE: begin
               if (pkt_valid && in_addr_ok) begin
                  header_d = data_in;
                  state_d  = empty_vec[in_addr] ? ST_LFD : ST_WAIT_EMPTY;
               end
            end
            ST_WAIT_EMPTY: begin
               if (sel_empty) state_d = ST_LFD;
            end
            ST_LFD: begin
               if (!sel_full) begin
                  write    = 1'b1;
                  wbyte    = header_q;
                  parity_d = header_q;
                  count_d  = '0;
                  error_d  = 1'b0;
                  state_d  = (len_q == '0) ? ST_LOAD_PARITY : ST_LOAD_DATA;
               end
            end
            ST_LOAD_DATA: begin
               if (pkt_valid && !sel_full) begin
                  write    = 1'b1;
                  wbyte    = data_in;
                  parity_d = parity_q ^ data_in;
                  count_d  = count_q + CW'(1);
                  if (count_d == len_q) state_d = ST_LOAD_PARITY;
               end else if (pkt_valid) begin
                  hold_d  = data_in;
                  state_d = ST_FULL;
               end
            end
            ST_FULL: begin
               if (!sel_full) state_d = ST_LAF;
            end
            // The held byte is only written once the FIFO has room, even if it refills in between.
            ST_LAF: begin
               if (!sel_full) begin
                  write    = 1'b1;
                  wbyte    = hold_q;
                  parity_d = parity_q ^ hold_q;
                  count_d  = count_q + CW'(1);
                  state_d  = (count_d == len_q) ? ST_LOAD_PARITY : ST_LOAD_DATA;
               end
            end
            ST_LOAD_PARITY: begin
               if (pkt_valid && !sel_full) begin
                  write       = 1'b1;
                  wbyte       = data_in;
                  rx_parity_d = data_in;
                  state_d     = ST_CHECK;
               end else if (pkt_valid) begin
                  hold_d  = data_in;
                  state_d = ST_PFULL;
               end
            end
            ST_PFULL: begin
               if (!sel_full) begin
                  write       = 1'b1;
                  wbyte       = hold_q;
                  rx_parity_d = hold_q;
                  state_d     = ST_CHECK;
               end
            end
            ST_CHECK: begin
               error_d = (rx_parity_q != parity_q);
               state_d = ST_DECODE;
            end
            default: state_d = ST_DECODE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_DECODE;
         header_q    <= '0;
         hold_q      <= '0;
         parity_q    <= '0;
         rx_parity_q <= '0;
         count_q     <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         header_q    <= header_d;
         hold_q      <= hold_d;
         parity_q    <= parity_d;
         rx_parity_q <= rx_parity_d;
         count_q     <= count_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         wr_en[i] = write && (addr_q == 2'(i));
      end
   end

   assign fifo_din  = wbyte;
   assign error     = error_q;
   assign lfd_state = (state_q == ST_LFD);
   assign busy      = (state_q == ST_WAIT_EMPTY) || (state_q == ST_LFD) || (state_q == ST_FULL) ||
                      (state_q == ST_LAF) || (state_q == ST_PFULL) || (state_q == ST_CHECK);

`ifdef ROUTER_WR_STATS_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        stat_check, stat_drop;

   assign stat_check = (state_q == ST_CHECK) && !sel_sr;
   assign stat_drop  = (state_q == ST_DECODE) && pkt_valid && !in_addr_ok;

   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      err_cnt_d  = err_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (stat_check && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (stat_check && (rx_parity_q != parity_q) && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (stat_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pkt_cnt_q  <= '0;
         err_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         err_cnt_q  <= err_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign err_cnt  = err_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_wr_ctrl.sv
`timescale 1ns/1ps
// tb_router_wr_ctrl: directed vector table plus randomized packets scored against a packet-level model.
module tb_router_wr_ctrl;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [2:0] fifo_full = 3'b000;
   logic [2:0] fifo_empty = 3'b111;
   logic [2:0] soft_reset = 3'b000;
   logic       busy, error, lfd_state;
   logic [2:0] wr_en;
   logic [7:0] fifo_din;
`ifdef ROUTER_WR_STATS_EN
   logic [15:0] pkt_cnt, err_cnt, drop_cnt;
`endif

   int checks = 0;
   int failures = 0;

   router_wr_ctrl #(.NUM_PORTS(3), .DW(8)) dut (
      .clock(clock),
      .resetn(resetn),
      .pkt_valid(pkt_valid),
      .data_in(data_in),
      .fifo_full(fifo_full),
      .fifo_empty(fifo_empty),
      .soft_reset(soft_reset),
      .busy(busy),
      .error(error),
      .wr_en(wr_en),
      .fifo_din(fifo_din),
      .lfd_state(lfd_state)
`ifdef ROUTER_WR_STATS_EN
      ,
      .pkt_cnt(pkt_cnt),
      .err_cnt(err_cnt),
      .drop_cnt(drop_cnt)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       pv;
      logic [7:0] din;
      logic [2:0] full;
      logic [2:0] empty;
      logic [2:0] sr;
      logic       busy;
      logic [2:0] wr;
      logic [7:0] fd;
      logic       lfd;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   // Random-phase packet model: bytes the source offers and bytes the selected FIFO must receive.
   logic [7:0] src_bytes[$];
   logic [7:0] exp_q[$];
   int         src_idx;
   int         exp_written;
   logic [1:0] cur_addr;
   logic       model_err;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic void addVec(input logic pv, input logic [7:0] din, input logic [2:0] full,
                                  input logic [2:0] empty, input logic [2:0] sr, input logic eb,
                                  input logic [2:0] ewr, input logic [7:0] efd, input logic elfd,
                                  input logic eerr);
      vec_t v;
      v.pv = pv; v.din = din; v.full = full; v.empty = empty; v.sr = sr;
      v.busy = eb; v.wr = ewr; v.fd = efd; v.lfd = elfd; v.err = eerr;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v, input int idx);
      @(posedge clock);
      #1;
      pkt_valid  = v.pv;
      data_in    = v.din;
      fifo_full  = v.full;
      fifo_empty = v.empty;
      soft_reset = v.sr;
      @(negedge clock);
      checkOutput($sformatf("v%0d_busy", idx), busy, v.busy);
      checkOutput($sformatf("v%0d_wr_en", idx), wr_en, v.wr);
      checkOutput($sformatf("v%0d_fifo_din", idx), fifo_din, v.fd);
      checkOutput($sformatf("v%0d_lfd", idx), lfd_state, v.lfd);
      checkOutput($sformatf("v%0d_error", idx), error, v.err);
   endtask

   task automatic runRandomCycle();
      logic [2:0] onehot;
      logic [7:0] e;
      @(posedge clock);
      #1;
      for (int p = 0; p < 3; p++) begin
         fifo_full[p]  = ($urandom_range(0, 3) == 0);
         fifo_empty[p] = ($urandom_range(0, 3) != 0);
      end
      soft_reset = 3'b000;
      if (!busy) begin
         if (src_idx < src_bytes.size()) begin
            pkt_valid = ($urandom_range(0, 4) != 0);
            data_in   = src_bytes[src_idx];
         end else begin
            pkt_valid = 1'b0;
            data_in   = 8'($urandom);
         end
      end
      @(negedge clock);
      if (wr_en != 3'b000) begin
         onehot = 3'b001 << cur_addr;
         checkOutput("rnd_wr_port", wr_en, onehot);
         checkOutput("rnd_wr_while_full", wr_en & fifo_full, 3'b000);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL rnd_extra_write actual=%0h expected=no_write", fifo_din);
         end else begin
            e = exp_q.pop_front();
            checkOutput("rnd_fifo_din", fifo_din, e);
            checkOutput("rnd_lfd", lfd_state, 32'(exp_written == 0));
            exp_written++;
         end
      end
      if (pkt_valid && !busy && src_idx < src_bytes.size()) src_idx++;
   endtask

   task automatic sendRandomPacket();
      int         len;
      int         budget;
      logic [1:0] addr;
      logic [7:0] hdr, par, b;
      logic       bad;
      addr = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      len  = $urandom_range(0, 6);
      hdr  = {6'(len), addr};
      bad  = 1'b0;
      src_bytes.delete();
      exp_q.delete();
      src_bytes.push_back(hdr);
      if (addr != 2'd3) begin
         par = hdr;
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            src_bytes.push_back(b);
            par = par ^ b;
         end
         bad = ($urandom_range(0, 3) == 0);
         src_bytes.push_back(bad ? (par ^ 8'h5A) : par);
         exp_q = src_bytes;
      end
      cur_addr    = addr;
      src_idx     = 0;
      exp_written = 0;
      budget      = 0;
      while (!(src_idx == src_bytes.size() && exp_q.size() == 0) && budget < 400) begin
         runRandomCycle();
         budget++;
      end
      checks++;
      if (budget >= 400) begin
         failures++;
         $display("[TB] FAIL rnd_timeout actual=%0d_bytes_left expected=0", exp_q.size());
      end
      runRandomCycle();
      runRandomCycle();
      if (addr != 2'd3) model_err = bad;
      checkOutput("rnd_error", error, model_err);
      checkOutput("rnd_busy_idle", busy, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_error", error, 1'b0);
      checkOutput("rst_wr_en", wr_en, 3'b000);
      checkOutput("rst_fifo_din", fifo_din, 8'h00);
      checkOutput("rst_lfd", lfd_state, 1'b0);
      resetn = 1'b1;

      // Good packet: addr 1, len 3, parity 0x0D
      addVec(1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      addVec(1, 8'h11, 3'b000, 3'b111, 3'b000, 1, 3'b010, 8'h0D, 1, 0);
      addVec(1, 8'h11, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'h11, 0, 0);
      addVec(1, 8'h22, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'h22, 0, 0);
      addVec(1, 8'h33, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'h33, 0, 0);
      addVec(1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'h0D, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      // Same packet, bad parity byte
      addVec(1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      addVec(1, 8'h11, 3'b000, 3'b111, 3'b000, 1, 3'b010, 8'h0D, 1, 0);
      addVec(1, 8'h11, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'h11, 0, 0);
      addVec(1, 8'h22, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'h22, 0, 0);
      addVec(1, 8'h33, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'h33, 0, 0);
      addVec(1, 8'hFF, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'hFF, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 1);
      // addr 2, len 1, FIFO 2 not empty for 5 cycles; error clears after LFD
      addVec(1, 8'h06, 3'b000, 3'b011, 3'b000, 0, 3'b000, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) addVec(1, 8'hAA, 3'b000, 3'b011, 3'b000, 1, 3'b000, 8'h00, 0, 1);
      addVec(1, 8'hAA, 3'b000, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 1);
      addVec(1, 8'hAA, 3'b000, 3'b111, 3'b000, 1, 3'b100, 8'h06, 1, 1);
      addVec(1, 8'hAA, 3'b000, 3'b111, 3'b000, 0, 3'b100, 8'hAA, 0, 0);
      addVec(1, 8'hAC, 3'b000, 3'b111, 3'b000, 0, 3'b100, 8'hAC, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      // Invalid address header is dropped
      addVec(1, 8'h03, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      // addr 0, len 4, FIFO 0 full for 3 cycles on the 2nd payload byte
      addVec(1, 8'h10, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      addVec(1, 8'h01, 3'b000, 3'b111, 3'b000, 1, 3'b001, 8'h10, 1, 0);
      addVec(1, 8'h01, 3'b000, 3'b111, 3'b000, 0, 3'b001, 8'h01, 0, 0);
      addVec(1, 8'h02, 3'b001, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      addVec(1, 8'h03, 3'b001, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 0);
      addVec(1, 8'h03, 3'b001, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 0);
      addVec(1, 8'h03, 3'b000, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 0);
      addVec(1, 8'h03, 3'b000, 3'b111, 3'b000, 1, 3'b001, 8'h02, 0, 0);
      addVec(1, 8'h03, 3'b000, 3'b111, 3'b000, 0, 3'b001, 8'h03, 0, 0);
      addVec(1, 8'h04, 3'b000, 3'b111, 3'b000, 0, 3'b001, 8'h04, 0, 0);
      addVec(1, 8'h14, 3'b000, 3'b111, 3'b000, 0, 3'b001, 8'h14, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      // soft_reset on another port is ignored; on the selected port it aborts
      addVec(1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      addVec(1, 8'h11, 3'b000, 3'b111, 3'b000, 1, 3'b010, 8'h0D, 1, 0);
      addVec(1, 8'h11, 3'b000, 3'b111, 3'b001, 0, 3'b010, 8'h11, 0, 0);
      addVec(1, 8'h22, 3'b000, 3'b111, 3'b010, 0, 3'b000, 8'h00, 0, 0);
      // Next byte is taken as a fresh header (addr 1, len 0)
      addVec(1, 8'h01, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 1, 3'b010, 8'h01, 1, 0);
      addVec(1, 8'h01, 3'b000, 3'b111, 3'b000, 0, 3'b010, 8'h01, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 1, 3'b000, 8'h00, 0, 0);
      addVec(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 3'b000, 8'h00, 0, 0);

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

`ifdef ROUTER_WR_STATS_EN
      checkOutput("stats_pkt_cnt", pkt_cnt, 16'd5);
      checkOutput("stats_err_cnt", err_cnt, 16'd1);
      checkOutput("stats_drop_cnt", drop_cnt, 16'd1);
`endif

      // Async reset mid-packet
      @(posedge clock); #1;
      pkt_valid = 1'b1; data_in = 8'h0D; fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
      @(negedge clock);
      @(posedge clock); #1;
      data_in = 8'h11;
      @(negedge clock);
      checkOutput("ar_lfd_before", lfd_state, 1'b1);
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("ar_wr_before", wr_en, 3'b010);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("ar_busy", busy, 1'b0);
      checkOutput("ar_wr_en", wr_en, 3'b000);
      checkOutput("ar_fifo_din", fifo_din, 8'h00);
      checkOutput("ar_lfd", lfd_state, 1'b0);
      checkOutput("ar_error", error, 1'b0);
`ifdef ROUTER_WR_STATS_EN
      checkOutput("ar_pkt_cnt", pkt_cnt, 16'd0);
      checkOutput("ar_drop_cnt", drop_cnt, 16'd0);
`endif
      pkt_valid = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("ar_busy_held", busy, 1'b0);
      resetn = 1'b1;

      // Randomized packets against the packet-level model
      model_err = 1'b0;
      for (int n = 0; n < 60; n++) sendRandomPacket();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
